// File: rtl/esdi_sector_monitor_if.sv
`default_nettype none
// ==================================================================
// esdi_sector_monitor_if : AXI4-Lite CSR bus for the sector monitor
// Revision 1.0
// ==================================================================
interface esdi_sector_monitor_if;
  logic        awvalid;
  logic        awready;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface
`default_nettype wire

// File: rtl/esdi_sector_monitor.sv
`default_nettype none
// ==================================================================
// esdi_sector_monitor : ESDI INDEX/SECTOR tracking and rotational timing CSRs
// Revision 1.0
// ==================================================================
module esdi_sector_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 csr_aclk,
  input  logic                 csr_areset,
  esdi_sector_monitor_if.slave csr,
  input  logic                 esdi_index,
  input  logic                 esdi_sector,
  output logic                 index_strobe,
  output logic                 sector_strobe,
  output logic [7:0]           sector_number
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] idx_sync, sec_sync;
  logic                   idx_prev, sec_prev;
  logic                   idx_rise, sec_rise, any_high, any_fall, strobe_evt;

  logic                 enable, armed, seen, locked, overflow, collision;
  logic [7:0]           sectors_per_rev;
  logic [CNT_WIDTH-1:0] rev_cnt, sp_cnt, pw_cnt;
  logic [31:0]          sector_period, rev_period, pulse_width;

  logic       aw_held, w_held, bvalid_q, rvalid_q, wr_commit;
  logic [2:0] aw_word, w_bits;
  logic [31:0] rdata_q, rd_mux;
  logic       unused;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  // A saturated counter reports all-ones regardless of counter width
  function automatic logic [31:0] widen(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? 32'hFFFF_FFFF : 32'(v);
  endfunction

  always_ff @(posedge csr_aclk) begin
    if (csr_areset) begin
      idx_sync <= '0;
      sec_sync <= '0;
      idx_prev <= 1'b0;
      sec_prev <= 1'b0;
    end else begin
      idx_sync <= {idx_sync[SYNC_STAGES-2:0], esdi_index};
      sec_sync <= {sec_sync[SYNC_STAGES-2:0], esdi_sector};
      idx_prev <= idx_sync[SYNC_STAGES-1];
      sec_prev <= sec_sync[SYNC_STAGES-1];
    end
  end

  assign idx_rise   = idx_sync[SYNC_STAGES-1] & ~idx_prev;
  assign sec_rise   = sec_sync[SYNC_STAGES-1] & ~sec_prev;
  assign any_high   = idx_sync[SYNC_STAGES-1] | sec_sync[SYNC_STAGES-1];
  assign any_fall   = (idx_prev | sec_prev) & ~any_high;
  assign strobe_evt = idx_rise | sec_rise;

  assign wr_commit = aw_held && w_held && (!bvalid_q || csr.bready);

  always_ff @(posedge csr_aclk) begin
    if (csr_areset) begin
      enable          <= 1'b0;
      armed           <= 1'b0;
      seen            <= 1'b0;
      locked          <= 1'b0;
      overflow        <= 1'b0;
      collision       <= 1'b0;
      index_strobe    <= 1'b0;
      sector_strobe   <= 1'b0;
      sector_number   <= '0;
      sectors_per_rev <= '0;
      rev_cnt         <= '0;
      sp_cnt          <= '0;
      pw_cnt          <= '0;
      sector_period   <= '0;
      rev_period      <= '0;
      pulse_width     <= '0;
    end else begin
      // Clears come first so a same-cycle hardware set below takes priority
      if (wr_commit && aw_word == 3'd1) begin
        if (w_bits[1]) overflow  <= 1'b0;
        if (w_bits[2]) collision <= 1'b0;
      end
      if (wr_commit && aw_word == 3'd0) enable <= w_bits[0];

      if (!enable) begin
        armed         <= 1'b0;
        seen          <= 1'b0;
        locked        <= 1'b0;
        index_strobe  <= 1'b0;
        sector_strobe <= 1'b0;
        sector_number <= '0;
        rev_cnt       <= '0;
        sp_cnt        <= '0;
        pw_cnt        <= '0;
      end else begin
        index_strobe  <= idx_rise;
        sector_strobe <= sec_rise & ~idx_rise;
        rev_cnt       <= idx_rise ? CNT_WIDTH'(1) : sat_inc(rev_cnt);
        sp_cnt        <= strobe_evt ? CNT_WIDTH'(1) : sat_inc(sp_cnt);
        if (strobe_evt) seen <= 1'b1;
        if (strobe_evt && seen) begin
          sector_period <= widen(sp_cnt);
          if (sp_cnt == CNT_MAX) overflow <= 1'b1;
        end

        if (idx_rise) begin
          sector_number <= '0;
          armed         <= 1'b1;
          if (sec_rise) collision <= 1'b1;
          if (armed) begin
            sectors_per_rev <= sector_number + 8'd1;
            rev_period      <= widen(rev_cnt);
            locked          <= 1'b1;
            if (rev_cnt == CNT_MAX) overflow <= 1'b1;
          end
        end else if (sec_rise) begin
          sector_number <= sector_number + 8'd1;
        end

        if (any_fall) begin
          pulse_width <= widen(pw_cnt);
          pw_cnt      <= '0;
          if (pw_cnt == CNT_MAX) overflow <= 1'b1;
        end else if (any_high) begin
          pw_cnt <= sat_inc(pw_cnt);
        end
      end
    end
  end

  always_ff @(posedge csr_aclk) begin
    if (csr_areset) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_word  <= '0;
      w_bits   <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (csr.awvalid && !aw_held) begin
        aw_held <= 1'b1;
        aw_word <= csr.awaddr[4:2];
      end else if (wr_commit) begin
        aw_held <= 1'b0;
      end
      if (csr.wvalid && !w_held) begin
        w_held <= 1'b1;
        w_bits <= csr.wdata[2:0];
      end else if (wr_commit) begin
        w_held <= 1'b0;
      end

      if (wr_commit)        bvalid_q <= 1'b1;
      else if (csr.bready)  bvalid_q <= 1'b0;

      if (csr.arvalid && csr.arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (csr.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr.araddr[4:2])
      3'd0:    rd_mux = {31'd0, enable};
      3'd1:    rd_mux = {29'd0, collision, overflow, locked};
      3'd2:    rd_mux = {24'd0, sector_number};
      3'd3:    rd_mux = {24'd0, sectors_per_rev};
      3'd4:    rd_mux = sector_period;
      3'd5:    rd_mux = rev_period;
      3'd6:    rd_mux = pulse_width;
      default: rd_mux = '0;
    endcase
  end

  assign csr.awready = !aw_held;
  assign csr.wready  = !w_held;
  assign csr.bvalid  = bvalid_q;
  assign csr.bresp   = 2'b00;
  assign csr.arready = !rvalid_q || csr.rready;
  assign csr.rvalid  = rvalid_q;
  assign csr.rdata   = rdata_q;
  assign csr.rresp   = 2'b00;

  assign unused = &{1'b0, csr.awaddr[1:0], csr.awprot, csr.araddr[1:0], csr.arprot,
                    csr.wstrb, csr.wdata[31:3]};

endmodule
`default_nettype wire

// File: tb/tb_esdi_sector_monitor.sv
`default_nettype none
// ==================================================================
// tb_esdi_sector_monitor : scoreboard bench with an event-level timing model
// Revision 1.0
// ==================================================================
module tb_esdi_sector_monitor;
  localparam int S    = 2;
  localparam int CW   = 12;
  localparam int MAXC = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       esdi_index = 1'b0;
  logic       esdi_sector = 1'b0;
  logic       index_strobe, sector_strobe;
  logic [7:0] sector_number;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  esdi_sector_monitor_if bus ();

  esdi_sector_monitor #(.SYNC_STAGES(S), .CNT_WIDTH(CW)) dut (
    .csr_aclk      (clk),
    .csr_areset    (rst),
    .csr           (bus),
    .esdi_index    (esdi_index),
    .esdi_sector   (esdi_sector),
    .index_strobe  (index_strobe),
    .sector_strobe (sector_strobe),
    .sector_number (sector_number)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_idx; int t; int snum; } strobe_t;
  typedef struct { logic [31:0] data; int t; int word; } rd_t;
  strobe_t exp_strobe[$];
  rd_t     exp_rd[$];
  int      exp_b[$];

  // Reference state: what firmware should observe, derived from pulse times
  bit          m_en, m_armed, m_seen, m_locked, m_ovf, m_col;
  int          m_snum, m_spr, m_last_t, m_last_idx;
  logic [31:0] m_sp, m_rp, m_pw;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(string name, string detail);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  function automatic void m_reset();
    m_en = 0; m_armed = 0; m_seen = 0; m_locked = 0; m_ovf = 0; m_col = 0;
    m_snum = 0; m_spr = 0; m_last_t = 0; m_last_idx = 0;
    m_sp = 0; m_rp = 0; m_pw = 0;
  endfunction

  function automatic logic [31:0] cap(int d);
    if (d >= MAXC) begin
      m_ovf = 1;
      return 32'hFFFF_FFFF;
    end
    return 32'(d);
  endfunction

  function automatic void m_strobe(bit is_idx, bit is_sec, int t);
    if (!m_en) return;
    if (m_seen) m_sp = cap(t - m_last_t);
    m_seen   = 1;
    m_last_t = t;
    if (is_idx) begin
      if (m_armed) begin
        m_spr    = (m_snum + 1) % 256;
        m_rp     = cap(t - m_last_idx);
        m_locked = 1;
      end
      m_armed    = 1;
      m_last_idx = t;
      m_snum     = 0;
      if (is_sec) m_col = 1;
    end else begin
      m_snum = (m_snum + 1) % 256;
    end
    exp_strobe.push_back('{is_idx, t, m_snum});
  endfunction

  function automatic logic [31:0] m_word(int w);
    case (w)
      0: return {31'd0, m_en};
      1: return {29'd0, m_col, m_ovf, m_locked};
      2: return 32'(m_snum);
      3: return 32'(m_spr);
      4: return m_sp;
      5: return m_rp;
      6: return m_pw;
      default: return 32'd0;
    endcase
  endfunction

  strobe_t s_pop;
  rd_t     r_pop;
  int      b_pop;

  always @(negedge clk) begin
    if (!rst) begin
      if (index_strobe || sector_strobe) begin
        if (exp_strobe.size() == 0) flag("strobe", "unexpected strobe");
        else begin
          s_pop = exp_strobe.pop_front();
          check("strobe kind", {index_strobe, sector_strobe}, s_pop.is_idx ? 64'd2 : 64'd1);
          check("strobe cycle", cyc, s_pop.t);
          check("strobe sector_number", sector_number, s_pop.snum);
        end
      end
      if (bus.rvalid) begin
        if (exp_rd.size() == 0) flag("rvalid", "unexpected read beat");
        else begin
          r_pop = exp_rd.pop_front();
          check($sformatf("rdata word%0d", r_pop.word), bus.rdata, r_pop.data);
          check("rvalid cycle", cyc, r_pop.t);
          check("rresp", bus.rresp, 0);
        end
      end
      if (bus.bvalid) begin
        if (exp_b.size() == 0) flag("bvalid", "unexpected write response");
        else begin
          b_pop = exp_b.pop_front();
          check("bvalid cycle", cyc, b_pop);
          check("bresp", bus.bresp, 0);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((exp_b.size() != 0 || exp_rd.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) flag("drain", "timeout waiting for bvalid/rvalid");
  endtask

  task automatic csr_write(int word, logic [31:0] d);
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = 5'(word * 4);
    bus.wvalid  = 1'b1; bus.wdata  = d;
    exp_b.push_back(cyc + 2);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (word == 0) begin
      m_en = d[0];
      if (!d[0]) begin m_armed = 0; m_seen = 0; m_locked = 0; m_snum = 0; end
    end
    if (word == 1) begin
      if (d[1]) m_ovf = 0;
      if (d[2]) m_col = 0;
    end
    drain();
  endtask

  task automatic read_words(int first, int last);
    for (int w = first; w <= last; w++) begin
      @(negedge clk);
      bus.arvalid = 1'b1;
      bus.araddr  = 5'(w * 4);
      exp_rd.push_back('{m_word(w), cyc + 1, w});
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    drain();
  endtask

  // Rise-to-rise period is exactly `spacing` cycles; spacing >= width + 6
  task automatic pulse(bit idx, bit sec, int width, int spacing);
    @(negedge clk);
    esdi_index  = idx;
    esdi_sector = sec;
    m_strobe(idx, sec, cyc + 1 + S);
    repeat (width) @(negedge clk);
    esdi_index  = 1'b0;
    esdi_sector = 1'b0;
    if (m_en) m_pw = cap(width);
    repeat (spacing - width - 1) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, sp, nsec;
    bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
    bus.wvalid  = 0; bus.wdata  = 0; bus.wstrb  = 4'hF;
    bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0;
    bus.bready  = 1; bus.rready = 1;
    m_reset();

    repeat (3) @(negedge clk);
    check("reset index_strobe", index_strobe, 0);
    check("reset sector_strobe", sector_strobe, 0);
    check("reset sector_number", sector_number, 0);
    check("reset readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("reset valids", {bus.bvalid, bus.rvalid}, 2'b00);
    rst = 1'b0;
    read_words(0, 7);

    // Directed revolution: 1000-cycle INDEX, three SECTORs at 250, 50-cycle pulses
    csr_write(0, 32'h1);
    pulse(1, 0, 50, 250);
    repeat (3) pulse(0, 1, 50, 250);
    pulse(1, 0, 50, 250);
    read_words(0, 7);

    // Simultaneous INDEX and SECTOR, then W1C of collision
    pulse(1, 1, 20, 100);
    read_words(1, 2);
    csr_write(1, 32'h4);
    read_words(1, 1);

    // Randomised revolutions, plus writes to read-only words
    for (int r = 0; r < 6; r++) begin
      w = $urandom_range(3, 40);
      pulse(1, ($urandom_range(0, 7) == 0), w, w + 6 + $urandom_range(0, 200));
      nsec = $urandom_range(0, 5);
      for (int k = 0; k < nsec; k++) begin
        w  = $urandom_range(3, 40);
        sp = w + 6 + $urandom_range(0, 200);
        pulse(0, 1, w, sp);
      end
      csr_write($urandom_range(2, 7), $urandom);
      read_words(1, 6);
    end

    // 256 SECTORs without INDEX wrap sector_number back to 0
    pulse(1, 0, 4, 20);
    repeat (256) pulse(0, 1, 2, 8);
    check("sector_number after wrap", sector_number, m_snum);
    read_words(1, 6);

    // Disable mid-revolution: live state clears, captures are retained
    pulse(0, 1, 3, 30);
    csr_write(0, 32'h0);
    check("sector_number disabled", sector_number, 0);
    read_words(0, 7);

    // Saturation of the sector period counter
    csr_write(0, 32'h1);
    pulse(0, 1, 4, MAXC + 900);
    pulse(0, 1, 4, 20);
    read_words(1, 6);
    csr_write(1, 32'h2);
    read_words(1, 1);

    // Reset while an AW is held drops it
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = 5'd0;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("awready while held", bus.awready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("awready after reset", bus.awready, 1);
    rst = 1'b0;
    m_reset();
    read_words(0, 7);

    check("strobes outstanding", exp_strobe.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/esdi_sector_monitor.md
# esdi_sector_monitor

Controller-side monitor for the ESDI INDEX and SECTOR lines. It synchronises both pulse inputs and tracks the current sector number. It also measures sector period, revolution period, pulse width and sectors per revolution, and flags protocol errors. Measurements and status are exposed through the same AXI4-Lite CSR slave style as the rest of the emulator, so firmware can check drive rotational timing.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth on esdi_index/esdi_sector (≥2)

Ports:
- csr_aclk  in  1  single clock for all logic
- csr_areset  in  1  synchronous, active-high reset
- csr_awvalid/csr_awready/csr_awaddr[4:0]/csr_awprot[2:0]  AXI-Lite write address
- csr_wvalid/csr_wready/csr_wdata[31:0]/csr_wstrb[3:0]  AXI-Lite write data; wstrb ignored
- csr_bvalid/csr_bready/csr_bresp[1:0]  AXI-Lite write response
- csr_arvalid/csr_arready/csr_araddr[4:0]/csr_arprot[2:0]  AXI-Lite read address
- csr_rvalid/csr_rready/csr_rdata[31:0]/csr_rresp[1:0]  AXI-Lite read data
- esdi_index  in  1  asynchronous INDEX pulse, active high
- esdi_sector  in  1  asynchronous SECTOR pulse, active high
- index_strobe  out  1  one-cycle pulse per detected INDEX rising edge
- sector_strobe  out  1  one-cycle pulse per detected SECTOR rising edge
- sector_number  out  8  current sector, 0 after INDEX

## Operation
- CSR map, word index addr[4:2]:
  - 0: control. bit0 = enable. R/W.
  - 1: status. bit0 = locked (RO), bit1 = overflow (sticky, W1C), bit2 = collision (sticky, W1C).
  - 2: sector_number. RO.
  - 3: sectors_per_rev. RO, 8 bits.
  - 4: sector_period. RO.
  - 5: rev_period. RO.
  - 6: pulse_width. RO.
  - 7: reads 0.
- Writes to RO or unmapped words are ignored but still return bresp 00.
- Rising edge is detected on the last synchroniser stage versus its previous value.
- INDEX edge:
  - sector_number ← 0.
  - If an INDEX has been seen since enable: sectors_per_rev ← sector_number+1 (8-bit wrap), rev_period ← cycles since previous INDEX strobe, locked ← 1.
  - Otherwise only arm.
- SECTOR edge: sector_number ← sector_number+1, wrapping 255→0.
- Any strobe other than the first since enable: sector_period ← cycles since previous strobe of either kind.
- Both edges in the same cycle: treated as INDEX only; collision ← 1.
- pulse_width counts synchronised cycles with either input high. It is captured on the falling edge of the OR of both inputs.
- All counters are 32-bit and saturate at 0xFFFFFFFF. A capture from a saturated counter stores 0xFFFFFFFF and sets overflow.
- enable=0 clears: counters, arm state, locked, sector_number, strobes. Captured registers and sticky bits are retained.
- Hardware set and W1C of a sticky bit in the same cycle: set wins.

## Timing
- Reset values: all CSRs 0, all outputs 0, awready/wready/arready 1.
- An input first sampled high at edge N produces a strobe high for exactly the cycle after edge N+SYNC_STAGES. sector_number updates in the same cycle as the strobe.
- Captured registers are valid in the strobe cycle. The CSR read reflects them from the next accepted read.
- Write channel:
  - awready = !aw_held; wready = !w_held. Address and data are captured independently.
  - The write commits when both are held and (!bvalid || bready).
  - bvalid rises the next cycle with bresp 00 and stays until bready.
- Read channel:
  - arready = !rvalid || rready.
  - rdata/rvalid are registered: 1-cycle latency, rresp 00, held until rready.
  - Back-to-back reads run at full throughput.
- Reset mid-transaction drops pending AW/W/B/R immediately.

## Test plan
- Reset, read all 8 words → every word 0. Each write returns bvalid with bresp 00 one cycle after AW+W.
- enable=1, then INDEX every 1000 cycles with 3 SECTORs at 250-cycle spacing, 50-cycle pulses:
  - After 2nd INDEX: locked=1, sectors_per_rev=4, rev_period=1000, sector_period=250, pulse_width=50.
  - sector_number steps 0,1,2,3.
- Single INDEX pulse: index_strobe high exactly 1 cycle, SYNC_STAGES+1 cycles after input rise. sector_number=0.
- Raise INDEX and SECTOR on the same cycle → collision=1 and sector_number=0. Write 0x4 to word 1 → collision=0.
- Force 2^32 cycles between pulses (or a reduced-width test build) → sector_period=0xFFFFFFFF and overflow=1.
- 256 SECTORs without INDEX → sector_number wraps to 0. Clear enable mid-revolution → sector_number=0 and locked=0; rev_period is retained.
